// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a LIFO return-address stack,
// plus sticky overflow/underflow flags and an illegal-op pulse.
module pc_stack_unit #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [2:0] op,
  input  logic [ADDR_W-1:0] target,
  input  logic err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [$clog2(DEPTH):0] depth_lvl,
  output logic stack_full,
  output logic stack_empty,
  output logic ovf_err,
  output logic unf_err,
  output logic ill_op
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam logic [2:0] OP_INC = 3'b001, OP_JUMP = 3'b010, OP_CALL = 3'b011,
                         OP_RET = 3'b100, OP_SKIP = 3'b101;
  logic [ADDR_W-1:0] stk [DEPTH];
  logic [ADDR_W-1:0] pc_nx, pc_inc, top;
  logic is_call, is_ret, push, pop, ovf_set, unf_set;
  always_comb begin
    stack_full  = depth_lvl == LW'(DEPTH);
    stack_empty = depth_lvl == '0;
    pc_inc  = pc + ADDR_W'(1);
    top     = stk[IW'(depth_lvl - LW'(1))];
    is_call = en && op == OP_CALL;
    is_ret  = en && op == OP_RET;
    push    = is_call && !stack_full;
    pop     = is_ret && !stack_empty;
    ovf_set = is_call && stack_full;
    unf_set = is_ret && stack_empty;
    pc_nx   = !en ? pc :
              op == OP_INC  ? pc_inc :
              op == OP_SKIP ? pc + ADDR_W'(2) :
              op == OP_JUMP || push ? target :
              pop ? top : pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      depth_lvl <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      ill_op    <= 1'b0;
    end else begin
      pc        <= pc_nx;
      depth_lvl <= push ? depth_lvl + LW'(1) : pop ? depth_lvl - LW'(1) : depth_lvl;
      ovf_err   <= ovf_set || (ovf_err && !err_clr);
      unf_err   <= unf_set || (unf_err && !err_clr);
      ill_op    <= en && op[2:1] == 2'b11;
    end
  end
  // Entries need no reset; depth_lvl alone defines which ones are valid.
  always_ff @(posedge clk) begin
    if (push && rst_n) stk[IW'(depth_lvl)] <= pc_inc;
  end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and random checks of pc_stack_unit against a
// queue-based reference model of the PC and return stack.
module tb_pc_stack_unit;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, err_clr = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] target = 8'h00;
  logic [7:0] pc;
  logic [2:0] depth_lvl;
  logic stack_full, stack_empty, ovf_err, unf_err, ill_op;
  int checks = 0, passed = 0;
  logic [7:0] mpc;
  logic [7:0] mstk[$];
  logic movf, munf, mill;

  pc_stack_unit #(.ADDR_W(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target), .err_clr(err_clr),
    .pc(pc), .depth_lvl(depth_lvl), .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .ill_op(ill_op)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mpc = 8'h00; mstk.delete(); movf = 0; munf = 0; mill = 0;
  endtask

  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] t, input logic c);
    en = e; op = o; target = t; err_clr = c;
    @(posedge clk);
    if (c) begin movf = 0; munf = 0; end
    mill = 0;
    if (e)
      case (o)
        3'd1: mpc = mpc + 8'd1;
        3'd5: mpc = mpc + 8'd2;
        3'd2: mpc = t;
        3'd3: if (mstk.size() < 4) begin mstk.push_back(mpc + 8'd1); mpc = t; end else movf = 1;
        3'd4: if (mstk.size() > 0) mpc = mstk.pop_back(); else munf = 1;
        3'd6, 3'd7: mill = 1;
        default: ;
      endcase
    #1;
    en = 0; op = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset();
    #7;
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    #12;
    checks++; if (pc !== 8'h00 || depth_lvl !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0)
      $display("FAIL reset_state pc=%h lvl=%0d e=%b f=%b want 00/0/1/0", pc, depth_lvl, stack_empty, stack_full);
    else passed++;
    checks++; if ({ovf_err, unf_err, ill_op} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {ovf_err, unf_err, ill_op});
    else passed++;
    @(negedge clk) rst_n = 1;
    step(1, 3'd3, 8'h50, 0);
    step(1, 3'd3, 8'h60, 0);
    step(1, 3'd2, 8'h37, 0);
    checks++; if (pc !== 8'h37 || depth_lvl !== 3'd2)
      $display("FAIL pre_async pc=%h lvl=%0d want 37/2", pc, depth_lvl);
    else passed++;
    #2 rst_n = 0;
    #1;
    checks++; if (pc !== 8'h00 || depth_lvl !== 3'd0 || stack_empty !== 1'b1)
      $display("FAIL async_reset pc=%h lvl=%0d e=%b want 00/0/1", pc, depth_lvl, stack_empty);
    else passed++;
    model_reset();
    @(negedge clk) rst_n = 1;
    step(1, 3'd1, 8'h00, 0);
    checks++; if (pc !== 8'h01) $display("FAIL after_reset_inc pc=%h want 01", pc); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_seq [4];
    logic [2:0] ops [4];
    exp_seq = '{8'hFF, 8'h00, 8'h02, 8'h01};
    ops = '{3'd1, 3'd1, 3'd5, 3'd5};
    step(1, 3'd2, 8'hFE, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) step(1, 3'd2, 8'hFF, 0);
      step(1, ops[i], 8'h00, 0);
      checks++; if (pc !== exp_seq[i]) $display("FAIL wrap_%0d pc=%h want %h", i, pc, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_call_ret();
    step(1, 3'd2, 8'h10, 0);
    step(1, 3'd3, 8'h40, 0);
    checks++; if (pc !== 8'h40 || depth_lvl !== 3'd1) $display("FAIL call1 pc=%h lvl=%0d want 40/1", pc, depth_lvl); else passed++;
    step(1, 3'd3, 8'h80, 0);
    checks++; if (pc !== 8'h80 || depth_lvl !== 3'd2) $display("FAIL call2 pc=%h lvl=%0d want 80/2", pc, depth_lvl); else passed++;
    step(1, 3'd4, 8'h00, 0);
    checks++; if (pc !== 8'h41 || depth_lvl !== 3'd1) $display("FAIL ret1 pc=%h lvl=%0d want 41/1", pc, depth_lvl); else passed++;
    step(1, 3'd4, 8'h00, 0);
    checks++; if (pc !== 8'h11 || stack_empty !== 1'b1) $display("FAIL ret2 pc=%h e=%b want 11/1", pc, stack_empty); else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] rets [4];
    rets = '{8'h31, 8'h21, 8'h11, 8'h01};
    step(1, 3'd2, 8'h00, 0);
    for (int i = 1; i <= 4; i++) step(1, 3'd3, 8'(i * 16), 0);
    checks++; if (pc !== 8'h40 || stack_full !== 1'b1 || depth_lvl !== 3'd4)
      $display("FAIL full pc=%h f=%b lvl=%0d want 40/1/4", pc, stack_full, depth_lvl);
    else passed++;
    step(1, 3'd3, 8'h50, 0);
    checks++; if (pc !== 8'h40 || ovf_err !== 1'b1 || depth_lvl !== 3'd4)
      $display("FAIL overflow pc=%h ovf=%b lvl=%0d want 40/1/4", pc, ovf_err, depth_lvl);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1, 3'd4, 8'h00, 0);
      checks++; if (pc !== rets[i]) $display("FAIL ovf_ret_%0d pc=%h want %h", i, pc, rets[i]); else passed++;
    end
    step(1, 3'd0, 8'h00, 1);
    checks++; if (ovf_err !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf_err); else passed++;
  endtask

  task automatic test_underflow();
    step(1, 3'd2, 8'h22, 0);
    step(1, 3'd4, 8'h00, 0);
    checks++; if (pc !== 8'h22 || unf_err !== 1'b1) $display("FAIL underflow pc=%h unf=%b want 22/1", pc, unf_err); else passed++;
    step(0, 3'd0, 8'h00, 1);
    checks++; if (unf_err !== 1'b0) $display("FAIL unf_clear got %b want 0", unf_err); else passed++;
    step(1, 3'd4, 8'h00, 1);
    checks++; if (unf_err !== 1'b1 || pc !== 8'h22) $display("FAIL set_wins unf=%b pc=%h want 1/22", unf_err, pc); else passed++;
    step(1, 3'd0, 8'h00, 1);
  endtask

  task automatic test_stall_ill();
    step(1, 3'd2, 8'h55, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd1, 8'h00, 0);
      checks++; if (pc !== 8'h55) $display("FAIL stall_%0d pc=%h want 55", i, pc); else passed++;
    end
    step(1, 3'd6, 8'h00, 0);
    checks++; if (pc !== 8'h55 || ill_op !== 1'b1) $display("FAIL ill_pulse pc=%h ill=%b want 55/1", pc, ill_op); else passed++;
    step(1, 3'd0, 8'h00, 0);
    checks++; if (ill_op !== 1'b0) $display("FAIL ill_one_cycle got %b want 0", ill_op); else passed++;
    step(0, 3'd7, 8'h00, 0);
    checks++; if (ill_op !== 1'b0) $display("FAIL ill_stalled got %b want 0", ill_op); else passed++;
  endtask

  task automatic test_random();
    logic [4:0] want;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 9) == 0);
      want = {mstk.size() == 4, mstk.size() == 0, movf, munf, mill};
      checks++; if (pc !== mpc) $display("FAIL rand_pc n=%0d got %h want %h", n, pc, mpc); else passed++;
      checks++; if (depth_lvl !== 3'(mstk.size())) $display("FAIL rand_lvl n=%0d got %0d want %0d", n, depth_lvl, mstk.size()); else passed++;
      checks++; if ({stack_full, stack_empty, ovf_err, unf_err, ill_op} !== want)
        $display("FAIL rand_flags n=%0d got %b want %b", n, {stack_full, stack_empty, ovf_err, unf_err, ill_op}, want);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_wrap();
    do_reset();
    test_call_ret();
    do_reset();
    test_overflow();
    do_reset();
    test_underflow();
    test_stall_ill();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter register and hardware return stack for the 8-bit microcontroller.
- Consumes the fetch-stage "next address" arithmetic. It keeps the current PC, advances it by 1 or 2, and loads jump targets.
- It also pushes and pops return addresses for call and return.
- Its output drives the program-memory address bus. Stack faults are reported to the control unit.

Parameters:
- ADDR_W, 8, width of PC, targets and stack entries.
- DEPTH, 4, number of return-stack entries (>=2).
- RESET_VEC, 8'h00, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; 0 = stall, all state held.
- op  input  3  operation: 000 HOLD, 001 INC, 010 JUMP, 011 CALL, 100 RET, 101 SKIP, 11x illegal.
- target  input  ADDR_W  destination address for JUMP/CALL.
- err_clr  input  1  clears the sticky error flags.
- pc  output  ADDR_W  current program counter (registered).
- depth_lvl  output  clog2(DEPTH)+1  number of valid stack entries.
- stack_full  output  1  depth_lvl == DEPTH.
- stack_empty  output  1  depth_lvl == 0.
- ovf_err  output  1  sticky: CALL attempted while full.
- unf_err  output  1  sticky: RET attempted while empty.
- ill_op  output  1  one-cycle pulse: illegal op accepted while en=1.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - pc=RESET_VEC, depth_lvl=0, stack_empty=1, stack_full=0.
  - ovf_err=0, unf_err=0, ill_op=0.
  - Stack contents are don't-care.
  - Reset mid-operation aborts any push or pop; the first edge after release behaves as a fresh start.
- Internal state: pc register, DEPTH x ADDR_W entry array, level counter 0..DEPTH. Stack is LIFO: the top is entry[depth_lvl-1].
- All ops take effect at the rising edge where en=1; results are visible on pc the following cycle (latency 1).
- With en=0, everything holds, including ill_op=0. err_clr is still honoured while en=0.
- HOLD: pc unchanged.
- INC: pc <= pc+1, modulo 2^ADDR_W (8'hFF -> 8'h00, no flag).
- SKIP: pc <= pc+2, modulo 2^ADDR_W (8'hFE -> 8'h00, 8'hFF -> 8'h01).
- JUMP: pc <= target; stack untouched.
- CALL, not full:
  - entry[depth_lvl] <= pc+1 (wrapped); depth_lvl += 1; pc <= target.
- CALL, full:
  - No push; pc unchanged; depth_lvl unchanged; ovf_err <= 1.
  - The control unit treats this as a fault.
- RET, not empty: pc <= entry[depth_lvl-1]; depth_lvl -= 1.
- RET, empty: pc unchanged; unf_err <= 1.
- Illegal op (110/111): treated as HOLD; ill_op=1 for exactly that cycle.
- Simultaneous err_clr and a new error: the set wins (flag stays 1).
- err_clr does not affect the pc or the stack.
- stack_full and stack_empty are combinational decodes of the registered depth_lvl, so they are glitch-free relative to clk.
- A CALL/RET sequence reaching exactly depth DEPTH is legal. The first push beyond it faults.
- target is sampled only on JUMP/CALL edges and may change freely otherwise.
- Synthesisable as flops only; no memory inference is required for DEPTH<=8.

Test Plan:
- Async reset: assert rst_n=0 mid-cycle with pc=8'h37 and depth 2 -> pc=8'h00, depth_lvl=0, stack_empty=1 immediately, without waiting for a clock edge.
- Wrap: from pc=8'hFE apply INC, INC, then SKIP -> pc sequence 8'hFF, 8'h00, 8'h02. From 8'hFF, SKIP -> 8'h01.
- Call/return: pc=8'h10, CALL target=8'h40 -> pc=8'h40, depth 1. Then CALL 8'h80 -> pc=8'h80, depth 2. Then RET -> 8'h41, then RET -> 8'h11, stack_empty=1.
- Overflow: DEPTH=4, five CALLs from pc=8'h00 with targets 8'h10, 8'h20, 8'h30, 8'h40, 8'h50 -> after the 4th, pc=8'h40 and stack_full=1. The 5th leaves pc=8'h40 and sets ovf_err=1. Four RETs then give 8'h31, 8'h21, 8'h11, 8'h01.
- Underflow and clear: RET on an empty stack at pc=8'h22 -> pc stays 8'h22, unf_err=1. err_clr pulse -> unf_err=0. err_clr coincident with a second empty RET -> unf_err stays 1.
- Stall and illegal op: en=0 with op=INC for 3 cycles -> pc is constant. en=1 with op=3'b110 -> pc unchanged and ill_op high for exactly one cycle. With en=0 and op=3'b111 -> ill_op stays 0.
